bcd_addsub_serial: RTL

- Parametrised N-digit 8421 BCD adder/subtractor that processes one digit per clock, LSD first, through a single shared digit-adder slice.
- Replaces wide ripple BCD adders in the arithmetic datapath wherever area matters more than latency.
- Start/done handshake; result and carry are held stable until the next accepted operation.

---
 rtl/bcd_addsub_serial.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_addsub_serial.sv
// bcd_addsub_serial
//   Digit-serial N-digit 8421 BCD adder/subtractor. One digit is processed per
//   clock, least significant digit first, through a single shared digit-adder
//   slice. Y/Cout/err are registered and held between completions.
//
//   Optional build macro: BCD_CHECK_EN
//     defined   - each latched A/B digit is checked as it is processed; any
//                 digit above 9 sets err at completion.
//     undefined - no check logic, err tied low.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   operation request, honoured only when not busy
//   sub    in   0: A+B+Cin, 1: A+(9's complement of B)+Cin
//   A, B   in   packed BCD operands, digit 0 at [3:0]
//   Cin    in   carry into digit 0
//   busy   out  high while digits are being processed
//   done   out  one-cycle pulse when Y/Cout/err are updated
//   Y      out  BCD result
//   Cout   out  decimal carry out of the most significant digit
//   err    out  invalid-digit flag
//
// State | meaning
//   IDLE | waiting for start
//   RUN  | one digit processed per clock
//   FIN  | result just loaded, done high; start here is accepted directly

module bcd_addsub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] A,
    input  logic [4*DIGITS-1:0] B,
    input  logic                Cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] Y,
    output logic                Cout,
    output logic                err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             c_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     res_q;
    logic             busy_q;
    logic             done_q;
    logic [W-1:0]     y_q;
    logic             cout_q;

    logic [4:0]       sum_d;
    logic [3:0]       dig_d;
    logic             carry_d;
    logic [W+3:0]     res_cat;
    logic [W-1:0]     res_d;
    logic             accept;
    logic             last_digit;

    // Per-digit 9's complement; invalid digits wrap modulo 16.
    function automatic logic [W-1:0] nines(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'd9 - v[4*i +: 4];
        end
        return r;
    endfunction

    assign accept     = start && (state_q != RUN);
    assign last_digit = (state_q == RUN) && (idx_q == IDX_LAST);

    // Shared digit slice: operands are shifted right each RUN cycle so the
    // current digit always sits at [3:0].
    always_comb begin
        sum_d   = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, c_q};
        dig_d   = sum_d[3:0];
        carry_d = 1'b0;
        if (sum_d > 5'd9) begin
            dig_d   = sum_d[3:0] + 4'd6;
            carry_d = 1'b1;
        end
        // New digit enters at the top; after DIGITS shifts digit 0 is at [3:0].
        // The extra nibble keeps this legal for DIGITS=1.
        res_cat = {dig_d, res_q};
        res_d   = res_cat[W+3:4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, FIN: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= sub ? nines(B) : B;
                        c_q     <= Cin;
                        idx_q   <= '0;
                        res_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    c_q   <= carry_d;
                    res_q <= res_d;
                    idx_q <= idx_q + IDX_W'(1);
                    if (last_digit) begin
                        y_q     <= res_d;
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BCD_CHECK_EN
    logic flag_q;
    logic err_q;
    logic dig_bad;

    // A complemented invalid B digit (10..15 -> 15..10) stays above 9, so
    // checking the latched B' digit is equivalent to checking B itself.
    assign dig_bad = (a_q[3:0] > 4'd9) || (b_q[3:0] > 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            flag_q <= 1'b0;
        end else if (state_q == RUN) begin
            flag_q <= flag_q | dig_bad;
            if (last_digit) begin
                err_q <= flag_q | dig_bad;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign Y    = y_q;
    assign Cout = cout_q;

endmodule
